// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- buffered 8N1 UART transmitter.
// Bytes written by the DDR test/status logic are queued in a small circular
// FIFO and serialised LSB first on uart_txd. There is one start bit, eight
// data bits, one stop bit and no parity. Everything runs on free_clk.
//
// Ports:
//   free_clk  in   only clock
//   rst       in   asynchronous active-high reset
//   wr_en     in   write strobe, one byte per cycle while high
//   wr_data   in   byte to queue
//   full      out  FIFO holds FIFO_DEPTH bytes
//   empty     out  FIFO holds no bytes
//   level     out  FIFO occupancy, clog2(FIFO_DEPTH)+1 bits
//   overflow  out  sticky, set when a write to a full FIFO is dropped
//   ovf_clr   in   clears overflow (a simultaneous drop wins)
//   tx_busy   out  a frame is on the line
//   uart_txd  out  serial line, idle high, driven straight from a flop
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          free_clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          overflow,
   input  logic                          ovf_clr,
   output logic                          tx_busy,
   output logic                          uart_txd
);
   localparam int BAUD_DIV = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int LW       = AW + 1;
   localparam int CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);

   generate
      if (BAUD_DIV < 4) begin : g_bad_baud
         $error("uart_tx_fifo: BAUD_DIV must be at least 4");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // FIFO storage with a registered read port
   logic [7:0]    mem [FIFO_DEPTH];
   logic [7:0]    rd_data_q;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q, level_d;
   logic          full_q, empty_q, ovf_q;
   logic          push_last_q;

   // Transmitter
   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          txd_q, txd_d;
   logic          busy_q;

   logic          push, drop, pop, baud_end, head_ready;

   assign push     = wr_en & ~full_q;
   assign drop     = wr_en & full_q;
   assign baud_end = (baud_q == BAUD_LAST);

   // rd_data_q samples the head one edge after it is written, so the head is
   // only usable when it was not written on the previous edge. With two or
   // more entries the head is always an older entry.
   assign head_ready = (level_q > LW'(1)) || ((level_q == LW'(1)) && !push_last_q);

   always_ff @(posedge free_clk) begin
      if (push) begin
         mem[wr_ptr_q] <= wr_data;
      end
      rd_data_q <= mem[rd_ptr_q];
   end

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (head_ready) begin
               pop     = 1'b1;
               shreg_d = rd_data_q;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         S_DATA: begin
            if (baud_end) begin
               baud_d  = '0;
               shreg_d = {1'b0, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         S_STOP: begin
            if (baud_end) begin
               baud_d = '0;
               if (head_ready) begin
                  // chain straight into the next frame, no idle gap
                  pop     = 1'b1;
                  shreg_d = rd_data_q;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + CW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // The line level is derived from the next state so the flop output lines
   // up exactly with the state it represents.
   always_comb begin
      txd_d = 1'b1;
      if (state_d == S_START) begin
         txd_d = 1'b0;
      end else if (state_d == S_DATA) begin
         txd_d = shreg_d[0];
      end
   end

   always_ff @(posedge free_clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         ovf_q       <= 1'b0;
         push_last_q <= 1'b0;
         state_q     <= S_IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         txd_q       <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         level_q     <= level_d;
         full_q      <= (level_d == DEPTH_L);
         empty_q     <= (level_d == '0);
         push_last_q <= push;
         if (drop) begin
            ovf_q <= 1'b1;
         end else if (ovf_clr) begin
            ovf_q <= 1'b0;
         end
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         txd_q   <= txd_d;
         busy_q  <= (state_d != S_IDLE);
      end
   end

   assign full     = full_q;
   assign empty    = empty_q;
   assign level    = level_q;
   assign overflow = ovf_q;
   assign tx_busy  = busy_q;
   assign uart_txd = txd_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo. DUT A runs at BAUD_DIV=10 with a 4-deep FIFO;
// DUT B uses the default parameters (BAUD_DIV=434). Expected bytes are queued
// when written and compared when a frame is decoded from the line.
module tb_uart_tx_fifo;
   logic       free_clk, rst;
   logic       wr_en, ovf_clr, wr_en_b, ovf_clr_b;
   logic [7:0] wr_data, wr_data_b;
   logic       full, empty, overflow, tx_busy, uart_txd;
   logic [2:0] level;
   logic       full_b, empty_b, overflow_b, tx_busy_b, uart_txd_b;
   logic [4:0] level_b;

   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];

   uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .FIFO_DEPTH(4)) dut_a (
      .free_clk(free_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .level(level), .overflow(overflow),
      .ovf_clr(ovf_clr), .tx_busy(tx_busy), .uart_txd(uart_txd)
   );

   uart_tx_fifo dut_b (
      .free_clk(free_clk), .rst(rst), .wr_en(wr_en_b), .wr_data(wr_data_b),
      .full(full_b), .empty(empty_b), .level(level_b), .overflow(overflow_b),
      .ovf_clr(ovf_clr_b), .tx_busy(tx_busy_b), .uart_txd(uart_txd_b)
   );

   initial free_clk = 1'b0;
   always #5 free_clk = ~free_clk;
   always @(posedge free_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic line_of(input int which);
      return (which == 0) ? uart_txd : uart_txd_b;
   endfunction

   function automatic logic busy_of(input int which);
      return (which == 0) ? tx_busy : tx_busy_b;
   endfunction

   // Called on a falling edge; the byte is captured by the next rising edge.
   // exp_line says whether the byte is expected to appear on the line.
   task automatic wr(input logic [7:0] d, input bit exp_line);
      wr_en   = 1'b1;
      wr_data = d;
      if (exp_line) exp_q.push_back(d);
      @(negedge free_clk);
      wr_en = 1'b0;
   endtask

   // Waits for a start bit, then checks every cycle of the frame against the
   // expected byte and that tx_busy stays high throughout. Returns at the
   // first cycle after the frame; t0 is the cycle of the first low sample.
   task automatic rx_frame(input int which, input int div, output int t0);
      int n, bad, busy_lo;
      logic [7:0] e, got;
      logic [9:0] efr;
      n = 0; bad = 0; busy_lo = 0; got = '0;
      while (line_of(which) !== 1'b0 && n < 30000) begin
         @(negedge free_clk);
         n++;
      end
      t0 = cyc;
      if (n >= 30000) begin
         check("rx_start_timeout", 0, 1);
         return;
      end
      if (exp_q.size() == 0) begin
         check("sb_underflow", 0, 1);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      efr = {1'b1, e, 1'b0};
      for (int c = 0; c < 10 * div; c++) begin
         if (line_of(which) !== efr[c / div]) bad++;
         if (busy_of(which) !== 1'b1) busy_lo++;
         if ((c % div) == div / 2 && c / div >= 1 && c / div <= 8) got[c / div - 1] = line_of(which);
         @(negedge free_clk);
      end
      $display("frame dut%0d t0=%0d data=0x%02h exp=0x%02h bad_samples=%0d", which, t0, got, e, bad);
      check("rx_data", {24'd0, got}, {24'd0, e});
      check("rx_line_samples", bad, 0);
      check("rx_busy_low", busy_lo, 0);
   endtask

   task automatic idle_check(input string tag, input int cycles);
      int hi;
      hi = 0;
      for (int i = 0; i < cycles; i++) begin
         if (uart_txd === 1'b1 && tx_busy === 1'b0) hi++;
         @(negedge free_clk);
      end
      check(tag, hi, cycles);
   endtask

   initial begin
      int w0, t0, ws, tb;
      int ts[6];
      rst = 1'b1; wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
      wr_en_b = 1'b0; wr_data_b = '0; ovf_clr_b = 1'b0;

      // reset state
      repeat (3) @(negedge free_clk);
      check("rst_txd", uart_txd, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_level", level, 0);
      check("rst_ovf", overflow, 0);
      rst = 1'b0;
      repeat (2) @(negedge free_clk);

      // single byte 0xA5
      wr(8'hA5, 1);
      w0 = cyc;
      check("single_level", level, 1);
      check("single_empty", empty, 0);
      @(negedge free_clk);
      check("single_pre_txd", uart_txd, 1);
      check("single_pre_busy", tx_busy, 0);
      rx_frame(0, 10, t0);
      check("single_latency", t0 - w0, 2);
      check("single_post_busy", tx_busy, 0);
      check("single_post_txd", uart_txd, 1);
      check("single_post_empty", empty, 1);
      idle_check("single_idle", 5);

      // back-to-back 0x00, 0xFF, 0x55
      wr(8'h00, 1); w0 = cyc; check("b2b_level1", level, 1);
      wr(8'hFF, 1); check("b2b_level2", level, 2);
      wr(8'h55, 1); check("b2b_level3", level, 2);
      rx_frame(0, 10, t0);
      check("b2b_latency", t0 - w0, 2);
      check("b2b_level_f1", level, 1);
      rx_frame(0, 10, tb);
      check("b2b_gap1", tb - t0, 100);
      check("b2b_level_f2", level, 0);
      rx_frame(0, 10, t0);
      check("b2b_gap2", t0 - tb, 100);
      check("b2b_empty", empty, 1);
      idle_check("b2b_idle", 5);

      // full / overflow / clear / write-while-full on a pop edge
      fork
         begin
            for (int k = 0; k < 6; k++) rx_frame(0, 10, ts[k]);
         end
         begin
            wr(8'h11, 1); ws = cyc; check("ovf_level1", level, 1);
            wr(8'h12, 1); check("ovf_level2", level, 2);
            wr(8'h13, 1); check("ovf_level3", level, 2);
            wr(8'h14, 1); check("ovf_level4", level, 3); check("ovf_full_n", full, 0);
            wr(8'h15, 1); check("ovf_level5", level, 4); check("ovf_full", full, 1);
            check("ovf_not_yet", overflow, 0);
            wr(8'h16, 0); check("ovf_level6", level, 4); check("ovf_set", overflow, 1);
            ovf_clr = 1'b1;
            @(negedge free_clk);
            ovf_clr = 1'b0;
            check("ovf_clr", overflow, 0);
            while (cyc < ws + 102) @(negedge free_clk);
            check("pop_level", level, 3);
            check("pop_full", full, 0);
            wr(8'h17, 1); check("refill_full", full, 1);
            while (cyc < ws + 201) @(negedge free_clk);
            wr(8'h18, 0);
            check("collide_level", level, 3);
            check("collide_ovf", overflow, 1);
         end
      join
      check("ovf_first_latency", ts[0] - ws, 2);
      for (int k = 1; k < 6; k++) check("ovf_gap", ts[k] - ts[k-1], 100);
      check("ovf_sb_empty", exp_q.size(), 0);
      idle_check("ovf_idle", 20);
      ovf_clr = 1'b1;
      @(negedge free_clk);
      ovf_clr = 1'b0;

      // mid-frame reset during data bit 3; neither byte is expected on the line
      wr(8'h81, 0); w0 = cyc;
      wr(8'h42, 0);
      while (cyc < w0 + 2 + 45) @(negedge free_clk);
      check("mid_pre_txd", uart_txd, 0);
      rst = 1'b1;
      #1;
      check("mid_rst_txd", uart_txd, 1);
      check("mid_rst_empty", empty, 1);
      check("mid_rst_level", level, 0);
      check("mid_rst_busy", tx_busy, 0);
      repeat (3) @(negedge free_clk);
      rst = 1'b0;
      @(negedge free_clk);
      wr(8'h3C, 1); w0 = cyc;
      rx_frame(0, 10, t0);
      check("mid_latency", t0 - w0, 2);
      idle_check("mid_idle", 30);

      // default parameters: BAUD_DIV = 434
      wr_en_b = 1'b1; wr_data_b = 8'h0D; exp_q.push_back(8'h0D);
      @(negedge free_clk);
      wr_en_b = 1'b0; w0 = cyc;
      rx_frame(1, 434, t0);
      check("dflt_latency", t0 - w0, 2);
      check("dflt_post_busy", tx_busy_b, 0);
      check("dflt_post_txd", uart_txd_b, 1);
      check("dflt_empty", empty_b, 1);
      check("dflt_level", level_b, 0);
      check("dflt_flags", {full_b, overflow_b}, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter for the DDR3 test top. It accepts bytes from the DDR test/status logic through a small synchronous FIFO and serialises them on `uart_txd`, the output opposite the host-driven `uart_rxd`. Status reports such as init-done, error flag and pass counters reach the host without stalling the test engine. It runs entirely in the `free_clk` domain.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: `free_clk` frequency in Hz.
- `BAUD`, 115200: line rate in bit/s.
- `FIFO_DEPTH`, 16: byte entries. Must be a power of 2, minimum 2.
- Derived `BAUD_DIV` = (CLK_FREQ + BAUD/2) / BAUD, which is 434 at the defaults. Elaboration fails if `BAUD_DIV` < 4.

Ports:
- `free_clk` in 1: the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: write strobe, one byte per cycle while high.
- `wr_data` in 8: byte to queue.
- `full` out 1: FIFO holds `FIFO_DEPTH` bytes.
- `empty` out 1: FIFO holds 0 bytes.
- `level` out clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `overflow` out 1: sticky. Set when a write is dropped.
- `ovf_clr` in 1: clears `overflow`.
- `tx_busy` out 1: a frame is in progress.
- `uart_txd` out 1: serial line, idle high.

## Operation
- The FIFO is a circular buffer with read/write pointers of clog2(FIFO_DEPTH) bits that wrap modulo depth. `level` is tracked separately.
- A write is accepted when `wr_en` is high and `full` is low.
  - When `wr_en` is high and `full` is high, the byte is dropped and `overflow` is set on the next edge.
  - A pop in the same cycle does not rescue a write to a full FIFO; the write is still dropped.
- Simultaneous accepted write and pop: `level` is unchanged and both pointers advance.
- `ovf_clr` and a dropped write in the same cycle: set wins.
- Transmit FSM states:
  - IDLE: `txd`=1. If the FIFO is not empty, pop the head into `shreg` and go to START.
  - START: `txd`=0 for `BAUD_DIV` cycles, then go to DATA with `bit_cnt`=0.
  - DATA: `txd`=`shreg`[0] for `BAUD_DIV` cycles, then shift right and increment `bit_cnt`. After 8 bits go to STOP. Bits go out LSB first.
  - STOP: `txd`=1 for `BAUD_DIV` cycles. At the end, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and resets on every state entry.
  - The bit boundary is at count == BAUD_DIV-1.
- No parity. One stop bit.
- `tx_busy` is 1 in START, DATA and STOP.

## Timing
- Reset values:
  - `uart_txd`=1, `tx_busy`=0, `empty`=1, `full`=0, `level`=0, `overflow`=0.
  - FSM in IDLE; pointers and counters 0.
- All outputs are registered. `uart_txd` comes straight from a flop, with no combinational path.
- Write latency: a write accepted at edge N gives `level`/`empty` updated after N.
- Start-bit latency: with the FSM in IDLE and the FIFO empty, an accepted write at edge N drives `uart_txd` low after edge N+2. It stays low for exactly `BAUD_DIV` cycles.
- Frame length is exactly 10·`BAUD_DIV` cycles. Back-to-back frames have zero extra cycles between the stop bit and the next start bit.
- Pop timing: the pop occurs on the edge leaving IDLE or STOP. `level` decrements and `full` deasserts after that edge.
- Reset asserted mid-frame:
  - `uart_txd` goes high immediately (asynchronously).
  - FIFO contents are discarded.
  - The host may see a framing error, which is acceptable.

## Test plan
Use `CLK_FREQ`=50_000_000, `BAUD`=5_000_000 (`BAUD_DIV`=10), `FIFO_DEPTH`=4 unless noted.
- Single byte: write 0xA5 after reset. Required line: low for 10 cycles starting 2 cycles after the write, then 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles. `tx_busy` is high for 100 cycles.
- Back-to-back: write 0x00, 0xFF, 0x55 on consecutive cycles. Required: three frames in exactly 300 contiguous cycles with no idle gap. `level` goes 1,2,2 and then decrements once per frame.
- Full/overflow: with the FSM busy, write 6 bytes. Required:
  - `full`=1 once `level`=4.
  - The next write sets `overflow`=1 and its byte never appears on the line.
  - `ovf_clr` clears `overflow`.
- Full plus pop collision: a write while full on the cycle the FSM pops. Required: the write is dropped, `overflow`=1, `level`=3.
- Mid-frame reset: assert `rst` during DATA bit 3. Required: `uart_txd`=1 asynchronously, `empty`=1. After release, a new write 0x3C transmits correctly.
- Default params: `BAUD_DIV`=434. A write of 0x0D produces a 4340-cycle frame.
